// File: rtl/stage_pipe_buf.sv
// Elastic FIFO buffer between adjacent pipeline stages, with a synchronous flush for branch redirect.
// Latency: 1 cycle from push to out_valid; there is no same-cycle bypass from in_data to out_data.
// Backpressure: in_ready comes from registered count only; DEPTH>=2 sustains 1 beat/cycle, DEPTH=1 gives 1 beat per 2 cycles.
module stage_pipe_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    // Pointer width; a single-entry buffer still carries a 1-bit pointer that stays at 0.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = rst & (count_q < FULL_CNT);
    assign out_valid = rst & (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state for occupancy and pointers; flush discards any push or pop in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state; reset outranks flush, which outranks push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; out_data is masked to zero whenever the head is invalid.
    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_stage_pipe_buf.sv
module tb_stage_pipe_buf;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // DEPTH=2, WIDTH=64 instance
    logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_flush;
    logic [63:0] d2_in_data, d2_out_data;
    logic [1:0]  d2_count;

    // DEPTH=3, WIDTH=64 instance
    logic        d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_flush;
    logic [63:0] d3_in_data, d3_out_data;
    logic [1:0]  d3_count;

    // DEPTH=1, WIDTH=8 instance
    logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_flush;
    logic [7:0]  d1_in_data, d1_out_data;
    logic [0:0]  d1_count;

    stage_pipe_buf #(.WIDTH(64), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst),
        .in_valid(d2_in_valid), .in_data(d2_in_data), .in_ready(d2_in_ready),
        .out_valid(d2_out_valid), .out_data(d2_out_data), .out_ready(d2_out_ready),
        .flush(d2_flush), .count(d2_count)
    );

    stage_pipe_buf #(.WIDTH(64), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst),
        .in_valid(d3_in_valid), .in_data(d3_in_data), .in_ready(d3_in_ready),
        .out_valid(d3_out_valid), .out_data(d3_out_data), .out_ready(d3_out_ready),
        .flush(d3_flush), .count(d3_count)
    );

    stage_pipe_buf #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst),
        .in_valid(d1_in_valid), .in_data(d1_in_data), .in_ready(d1_in_ready),
        .out_valid(d1_out_valid), .out_data(d1_out_data), .out_ready(d1_out_ready),
        .flush(d1_flush), .count(d1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs driven after this are taken at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (d2_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", d2_in_ready); end
        checks++;
        if (d2_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", d2_out_valid); end
        checks++;
        if (d2_out_data !== 64'd0) begin errors++; $display("FAIL rst_out_data got %h exp 0", d2_out_data); end
        checks++;
        if (d2_count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", d2_count); end
        rst = 1'b1;
        tick();
        checks++;
        if (d2_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b exp 1", d2_in_ready); end
        checks++;
        if (d2_count !== 2'd0 || d2_out_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_state count %0d vld %0b exp 0 0", d2_count, d2_out_valid);
        end
    endtask

    task automatic test_single_beat();
        d2_in_valid  = 1'b1;
        d2_in_data   = 64'hDEADBEEF_00000001;
        d2_out_ready = 1'b0;
        tick();
        d2_in_valid = 1'b0;
        d2_in_data  = 64'h0;
        checks++;
        if (d2_out_valid !== 1'b1 || d2_out_data !== 64'hDEADBEEF_00000001 || d2_count !== 2'd1) begin
            errors++;
            $display("FAIL single_latency vld %0b data %h count %0d exp 1 deadbeef00000001 1",
                     d2_out_valid, d2_out_data, d2_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (d2_out_valid !== 1'b1 || d2_out_data !== 64'hDEADBEEF_00000001) begin
                errors++;
                $display("FAIL single_hold%0d vld %0b data %h exp 1 deadbeef00000001", i, d2_out_valid, d2_out_data);
            end
        end
        d2_out_ready = 1'b1;
        tick();
        d2_out_ready = 1'b0;
        checks++;
        if (d2_out_valid !== 1'b0 || d2_count !== 2'd0 || d2_out_data !== 64'd0) begin
            errors++;
            $display("FAIL single_drain vld %0b count %0d data %h exp 0 0 0", d2_out_valid, d2_count, d2_out_data);
        end
    endtask

    task automatic test_full_backpressure();
        d3_out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            d3_in_valid = 1'b1;
            d3_in_data  = 64'(i);
            tick();
        end
        checks++;
        if (d3_count !== 2'd3 || d3_in_ready !== 1'b0) begin
            errors++; $display("FAIL full_state count %0d rdy %0b exp 3 0", d3_count, d3_in_ready);
        end
        d3_in_data = 64'd4;
        tick();
        checks++;
        if (d3_count !== 2'd3 || d3_in_ready !== 1'b0) begin
            errors++; $display("FAIL full_ignore count %0d rdy %0b exp 3 0", d3_count, d3_in_ready);
        end
        d3_in_valid  = 1'b0;
        d3_out_ready = 1'b1;
        checks++;
        if (d3_out_data !== 64'd1) begin errors++; $display("FAIL full_head got %0d exp 1", d3_out_data); end
        tick();
        checks++;
        if (d3_in_ready !== 1'b1 || d3_out_data !== 64'd2 || d3_count !== 2'd2) begin
            errors++;
            $display("FAIL full_pop1 rdy %0b data %0d count %0d exp 1 2 2", d3_in_ready, d3_out_data, d3_count);
        end
        tick();
        checks++;
        if (d3_out_data !== 64'd3 || d3_count !== 2'd1) begin
            errors++; $display("FAIL full_pop2 data %0d count %0d exp 3 1", d3_out_data, d3_count);
        end
        tick();
        checks++;
        if (d3_out_valid !== 1'b0 || d3_count !== 2'd0) begin
            errors++; $display("FAIL full_empty vld %0b count %0d exp 0 0", d3_out_valid, d3_count);
        end
        d3_out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        d2_in_valid  = 1'b1;
        d2_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d2_in_data = 64'(i);
            tick();
            checks++;
            if (d2_out_valid !== 1'b1 || d2_out_data !== 64'(i) || d2_count !== 2'd1 || d2_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream%0d vld %0b data %0d count %0d rdy %0b exp 1 %0d 1 1",
                         i, d2_out_valid, d2_out_data, d2_count, d2_in_ready, i);
            end
        end
        d2_in_valid = 1'b0;
        tick();
        d2_out_ready = 1'b0;
        checks++;
        if (d2_out_valid !== 1'b0 || d2_count !== 2'd0) begin
            errors++; $display("FAIL stream_end vld %0b count %0d exp 0 0", d2_out_valid, d2_count);
        end
    endtask

    task automatic test_flush();
        // Flush a full buffer while upstream and downstream are both active.
        d2_out_ready = 1'b0;
        d2_in_valid  = 1'b1;
        d2_in_data   = 64'hA;
        tick();
        d2_in_data = 64'hB;
        tick();
        checks++;
        if (d2_count !== 2'd2) begin errors++; $display("FAIL flush_fill count %0d exp 2", d2_count); end
        d2_in_data   = 64'hC;
        d2_out_ready = 1'b1;
        d2_flush     = 1'b1;
        tick();
        d2_flush     = 1'b0;
        d2_in_valid  = 1'b0;
        d2_out_ready = 1'b0;
        checks++;
        if (d2_count !== 2'd0 || d2_out_valid !== 1'b0 || d2_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full count %0d vld %0b rdy %0b exp 0 0 1", d2_count, d2_out_valid, d2_in_ready);
        end
        d2_in_valid = 1'b1;
        d2_in_data  = 64'hD;
        tick();
        d2_in_valid = 1'b0;
        checks++;
        if (d2_out_valid !== 1'b1 || d2_out_data !== 64'hD || d2_count !== 2'd1) begin
            errors++;
            $display("FAIL flush_next vld %0b data %h count %0d exp 1 d 1", d2_out_valid, d2_out_data, d2_count);
        end
        // Flush with one entry held: the push and pop in that cycle are both real and both discarded.
        d2_in_valid  = 1'b1;
        d2_in_data   = 64'hE;
        d2_out_ready = 1'b1;
        d2_flush     = 1'b1;
        tick();
        d2_flush     = 1'b0;
        d2_in_valid  = 1'b0;
        d2_out_ready = 1'b0;
        checks++;
        if (d2_count !== 2'd0 || d2_out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_one count %0d vld %0b exp 0 0", d2_count, d2_out_valid);
        end
        d2_in_valid = 1'b1;
        d2_in_data  = 64'hF;
        tick();
        d2_in_valid = 1'b0;
        checks++;
        if (d2_out_data !== 64'hF || d2_count !== 2'd1) begin
            errors++; $display("FAIL flush_one_next data %h count %0d exp f 1", d2_out_data, d2_count);
        end
        d2_out_ready = 1'b1;
        tick();
        d2_out_ready = 1'b0;
    endtask

    task automatic test_depth1();
        logic [7:0] vals [3];
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        d1_in_valid  = 1'b1;
        d1_out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            checks++;
            if (d1_in_ready !== ((cyc % 2) == 0)) begin
                errors++; $display("FAIL d1_rdy%0d got %0b exp %0b", cyc, d1_in_ready, (cyc % 2) == 0);
            end
            if ((cyc % 2) == 1) begin
                checks++;
                if (d1_out_valid !== 1'b1 || d1_out_data !== vals[cyc / 2]) begin
                    errors++;
                    $display("FAIL d1_out%0d vld %0b data %h exp 1 %h", cyc, d1_out_valid, d1_out_data, vals[cyc / 2]);
                end
            end
            d1_in_data = vals[cyc / 2];
            tick();
        end
        d1_in_valid = 1'b0;
        checks++;
        if (d1_out_valid !== 1'b0 || d1_count !== 1'b0) begin
            errors++; $display("FAIL d1_end vld %0b count %0d exp 0 0", d1_out_valid, d1_count);
        end
        d1_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        d3_in_valid = 1'b1;
        d3_in_data  = 64'h55;
        tick();
        d3_in_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (d3_out_valid !== 1'b0 || d3_out_data !== 64'd0 || d3_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_during vld %0b data %h rdy %0b exp 0 0 0", d3_out_valid, d3_out_data, d3_in_ready);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (d3_count !== 2'd0 || d3_out_valid !== 1'b0 || d3_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after count %0d vld %0b rdy %0b exp 0 0 1", d3_count, d3_out_valid, d3_in_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        d2_in_valid = 1'b0; d2_in_data = '0; d2_out_ready = 1'b0; d2_flush = 1'b0;
        d3_in_valid = 1'b0; d3_in_data = '0; d3_out_ready = 1'b0; d3_flush = 1'b0;
        d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0; d1_flush = 1'b0;
        test_reset();
        test_single_beat();
        test_full_backpressure();
        test_streaming();
        test_flush();
        test_depth1();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
